// File: rtl/conv_fprop_acc_drain.sv
// Accumulate/drain stage behind the conv_fprop product multiplier: tags, per-packet dot-product, shift, saturate.
// Optional feature macro: CONV_FPROP_ACC_ROUND_EN (round-half-up before the final shift).
module conv_fprop_acc_drain #(
    parameter int unsigned MUL_LAT    = 1,
    parameter int unsigned din_WIDTH  = 58,
    parameter int unsigned acc_WIDTH  = 64,
    parameter int unsigned SHIFT      = 16,
    parameter int unsigned dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    output logic                  pipe_ce,
    input  logic                  issue_valid,
    input  logic                  issue_last,
    input  logic [din_WIDTH-1:0]  din,
    output logic [dout_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag
);

    typedef enum logic {ST_ACCUM, ST_FULL} state_t;

    localparam logic signed [acc_WIDTH-1:0] ACC_MAX = {1'b0, {(acc_WIDTH-1){1'b1}}};
    localparam logic signed [acc_WIDTH-1:0] ACC_MIN = {1'b1, {(acc_WIDTH-1){1'b0}}};
    localparam logic signed [acc_WIDTH-1:0] OUT_MAX_EXT =
        {{(acc_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [acc_WIDTH-1:0] OUT_MIN_EXT =
        {{(acc_WIDTH-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] OUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] OUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
`ifdef CONV_FPROP_ACC_ROUND_EN
    localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [acc_WIDTH-1:0] RND_ADD =
        (SHIFT > 0) ? (acc_WIDTH'(1) << RND_POS) : '0;
`endif

    // Saturating signed add; returns {overflow, clamped sum}.
    function automatic logic [acc_WIDTH:0] sat_add(input logic signed [acc_WIDTH-1:0] a,
                                                   input logic signed [acc_WIDTH-1:0] b);
        logic [acc_WIDTH:0] wide;
        wide = {a[acc_WIDTH-1], a} + {b[acc_WIDTH-1], b};
        if (wide[acc_WIDTH] != wide[acc_WIDTH-1]) begin
            sat_add = {1'b1, (wide[acc_WIDTH] ? ACC_MIN : ACC_MAX)};
        end else begin
            sat_add = {1'b0, wide[acc_WIDTH-1:0]};
        end
    endfunction

    state_t                       state_q, state_d;
    logic [MUL_LAT-1:0]           vld_q, vld_d;
    logic [MUL_LAT-1:0]           lst_q, lst_d;
    logic signed [acc_WIDTH-1:0]  acc_q, acc_d;
    logic                         first_q, first_d;
    logic [dout_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         sat_q, sat_d;

    logic                         adv;
    logic                         t_valid;
    logic                         t_last;
    logic signed [acc_WIDTH-1:0]  din_ext;
    logic signed [acc_WIDTH-1:0]  base;
    logic [acc_WIDTH:0]           sa_acc;
    logic signed [acc_WIDTH-1:0]  sum;
    logic signed [acc_WIDTH-1:0]  pre;
    logic                         rnd_ovf;
    logic signed [acc_WIDTH-1:0]  shifted;
    logic [dout_WIDTH-1:0]        res;
    logic                         out_ovf;

    // Datapath: running sum, optional rounding, shift and output clamp.
    always_comb begin
        adv     = ce & ~(out_valid_q & ~out_ready);
        t_valid = vld_q[MUL_LAT-1];
        t_last  = lst_q[MUL_LAT-1];
        din_ext = acc_WIDTH'($signed(din));
        base    = first_q ? '0 : acc_q;
        sa_acc  = sat_add(base, din_ext);
        sum     = sa_acc[acc_WIDTH-1:0];
`ifdef CONV_FPROP_ACC_ROUND_EN
        {rnd_ovf, pre} = sat_add(sum, RND_ADD);
`else
        rnd_ovf = 1'b0;
        pre     = sum;
`endif
        shifted = pre >>> SHIFT;
        out_ovf = 1'b0;
        res     = dout_WIDTH'(shifted);
        if (shifted > OUT_MAX_EXT) begin
            res     = OUT_MAX;
            out_ovf = 1'b1;
        end else if (shifted < OUT_MIN_EXT) begin
            res     = OUT_MIN;
            out_ovf = 1'b1;
        end
    end

    // Next state: tag line shift, accumulate, complete, drain.
    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        lst_d       = lst_q;
        acc_d       = acc_q;
        first_d     = first_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        if (state_q == ST_FULL && out_ready) begin
            state_d     = ST_ACCUM;
            out_valid_d = 1'b0;
        end

        if (adv) begin
            vld_d[0] = issue_valid;
            lst_d[0] = issue_last;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                lst_d[i] = lst_q[i-1];
            end
            if (t_valid) begin
                if (t_last) begin
                    out_data_d  = res;
                    out_valid_d = 1'b1;
                    first_d     = 1'b1;
                    state_d     = ST_FULL;
                    sat_d       = sat_q | sa_acc[acc_WIDTH] | rnd_ovf | out_ovf;
                end else begin
                    acc_d   = sum;
                    first_d = 1'b0;
                    sat_d   = sat_q | sa_acc[acc_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign pipe_ce   = adv;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_fprop_acc_drain.sv
// Directed bench for conv_fprop_acc_drain with a one-stage ce-gated multiplier stand-in.
module tb_conv_fprop_acc_drain;

    localparam int unsigned DW = 58;
    localparam int unsigned OW = 32;
`ifdef CONV_FPROP_ACC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b1;
    logic          pipe_ce;
    logic          issue_valid = 1'b0;
    logic          issue_last = 1'b0;
    logic [DW-1:0] prod = '0;
    logic [DW-1:0] din = '0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          sat_flag;

    int tests = 0;
    int fails = 0;
    logic [OW-1:0] res_q[$];

    conv_fprop_acc_drain dut (
        .clk(clk), .reset(reset), .ce(ce), .pipe_ce(pipe_ce),
        .issue_valid(issue_valid), .issue_last(issue_last), .din(din),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product registered on advancing edges only.
    always @(posedge clk) if (pipe_ce) din <= prod;

    always @(negedge clk) if (out_valid && out_ready) res_q.push_back(out_data);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic v, input logic l, input logic [DW-1:0] p);
        logic seen;
        int   n;
        issue_valid = v;
        issue_last  = l;
        prod        = p;
        n           = 0;
        seen        = 1'b0;
        do begin
            @(negedge clk);
            seen = pipe_ce;
            @(posedge clk);
            #1;
            n++;
        end while (!seen && n < 50);
        if (!seen) check("issue_timeout", 64'd0, 64'd1);
        issue_valid = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [OW-1:0] exp);
        int n;
        n = 0;
        while (res_q.size() == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (res_q.size() == 0) check({name, "_timeout"}, 64'd0, 64'd1);
        else check(name, 64'(res_q.pop_front()), 64'(exp));
    endtask

    typedef struct {
        string         name;
        int unsigned   n;
        logic [DW-1:0] p0, p1, p2;
        logic [OW-1:0] exp_trn, exp_rnd;
        logic          sat_trn, sat_rnd;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"neg_pair",  2, -58'sh10000, -58'sh8000, '0,
                   32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[1] = '{"no_residue", 2, 58'h12345, 58'h0, '0,
                   32'h1, 32'h1, 1'b0, 1'b0};
        tbl[2] = '{"max_exact", 1, 58'h7FFF_FFFF_0000, '0, '0,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0};
        tbl[3] = '{"max_half",  1, 58'h7FFF_FFFF_8000, '0, '0,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{"pos_sat",   1, 58'h1_0000_0000_0000, '0, '0,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{"neg_min",   1, -58'sh8000_0000_0000, '0, '0,
                   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_sat_flag",  64'(sat_flag),  64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("pipe_ce_after_rst", 64'(pipe_ce), 64'd1);
        ce = 1'b0;
        #1;
        check("pipe_ce_follows_ce", 64'(pipe_ce), 64'd0);
        ce = 1'b1;
        @(posedge clk);
        #1;

        // Three-term packet with latency check
        issue(1'b1, 1'b0, 58'h10000);
        issue(1'b1, 1'b0, 58'h20000);
        issue_valid = 1'b1;
        issue_last  = 1'b1;
        prod        = -58'sh8000;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        check("t1_valid_edge1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("t1_valid_edge2", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), RND ? 64'd3 : 64'd2);
        get_result("t1_accepted", RND ? 32'd3 : 32'd2);

        // Table of packets
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, tbl[i].n == 1, tbl[i].p0);
            if (tbl[i].n >= 2) issue(1'b1, tbl[i].n == 2, tbl[i].p1);
            if (tbl[i].n >= 3) issue(1'b1, 1'b1, tbl[i].p2);
            get_result(tbl[i].name, RND ? tbl[i].exp_rnd : tbl[i].exp_trn);
            check({tbl[i].name, "_sat"}, 64'(sat_flag), RND ? 64'(tbl[i].sat_rnd) : 64'(tbl[i].sat_trn));
        end

        // Backpressure: result held, lane frozen, next sum exact
        out_ready = 1'b0;
        issue(1'b1, 1'b1, 58'h10000);
        issue(1'b1, 1'b0, 58'h20000);
        issue_valid = 1'b1;
        issue_last  = 1'b1;
        prod        = 58'h30000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_pipe_ce", 64'(pipe_ce), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'd1);
            check("hold_din", 64'(din), 64'h20000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_pipe_ce", 64'(pipe_ce), 64'd1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        get_result("held_result", 32'd1);
        get_result("after_hold", 32'd5);

        // Back-to-back single-term packets
        repeat (2) @(posedge clk);
        #1;
        res_q.delete();
        issue(1'b1, 1'b1, 58'h30000);
        issue(1'b1, 1'b1, 58'h50000);
        check("b2b_valid0", 64'(out_valid), 64'd1);
        check("b2b_data0", 64'(out_data), 64'd3);
        @(posedge clk);
        #1;
        check("b2b_valid1", 64'(out_valid), 64'd1);
        check("b2b_data1", 64'(out_data), 64'd5);
        @(posedge clk);
        #1;
        check("b2b_valid_drop", 64'(out_valid), 64'd0);
        get_result("b2b_q0", 32'd3);
        get_result("b2b_q1", 32'd5);

        // ce stall and issue gaps mid-packet
        issue(1'b1, 1'b0, 58'h10000);
        issue(1'b0, 1'b0, 58'h7777);
        ce          = 1'b0;
        issue_valid = 1'b1;
        prod        = 58'h20000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ce_stall_pipe_ce", 64'(pipe_ce), 64'd0);
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        issue(1'b1, 1'b0, 58'h20000);
        issue(1'b0, 1'b0, 58'h1234);
        issue(1'b1, 1'b1, -58'sh8000);
        get_result("stall_gap", RND ? 32'd3 : 32'd2);

        // Reset mid-packet
        issue(1'b1, 1'b0, 58'h10000);
        issue(1'b1, 1'b0, 58'h20000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sat", 64'(sat_flag), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        check("mid_rst_pipe_ce", 64'(pipe_ce), 64'd1);
        @(posedge clk);
        #1;
        issue(1'b1, 1'b1, 58'h40000);
        get_result("post_rst", 32'd4);
        check("post_rst_sat", 64'(sat_flag), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
